aes_block_loader: RTL



---
 rtl/aes_loader_pkg.sv | 33 +++
 rtl/aes_block_loader_if.sv | 37 +++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/aes_block_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_loader_pkg.sv
// -----------------------------------------------------------------------------
// aes_loader_pkg
// Shared constants for the AES block loader. It holds the last-beat marker, the
// default register addresses and the read response codes. The package also
// defines the read-address decode enum and a helper that packs the status word.
// -----------------------------------------------------------------------------
package aes_loader_pkg;

    localparam logic [15:0] LAST_MARKER     = 16'h1111;
    localparam logic [31:0] DEF_LOAD_ADDR   = 32'h0000_0510;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0514;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [1:0]  RESP_SLVERR     = 2'b10;

    typedef enum logic [1:0] {
        RD_LOAD   = 2'd0,
        RD_STATUS = 2'd1,
        RD_OTHER  = 2'd2
    } rd_sel_e;

    // Status word: [31:16] blocks done, [15:8] FIFO level, [2] missing-marker
    // error, [1] short-block error, [0] output valid.
    function automatic logic [31:0] pack_status(
        input logic [15:0] blocks_done,
        input logic [7:0]  level,
        input logic        err_missing,
        input logic        err_short,
        input logic        out_valid
    );
        return {blocks_done, level, 5'b00000, err_missing, err_short, out_valid};
    endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// -----------------------------------------------------------------------------
// aes_block_loader_if
// Bundles the loader's three channels:
//   write beats : wr_addr, wvalid, wready, wdata
//   reads       : arvalid_q, araddr_q, rvalid, rready, rdata, rresp
//   block out   : out_valid, out_ready, out_key, out_din
// The master modport belongs to the driver/consumer side.
// The slave modport belongs to the loader itself.
// -----------------------------------------------------------------------------
interface aes_block_loader_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [31:0]              wr_addr;
    logic                     wvalid;
    logic                     wready;
    logic [31:0]              wdata;
    logic                     arvalid_q;
    logic [31:0]              araddr_q;
    logic                     rvalid;
    logic                     rready;
    logic [31:0]              rdata;
    logic [1:0]               rresp;
    logic                     out_valid;
    logic                     out_ready;
    logic [BLOCK_BYTES*8-1:0] out_key;
    logic [BLOCK_BYTES*8-1:0] out_din;

    modport master (
        output wr_addr, wvalid, wdata, arvalid_q, araddr_q, rready, out_ready,
        input  wready, rvalid, rdata, rresp, out_valid, out_key, out_din
    );

    modport slave (
        input  wr_addr, wvalid, wdata, arvalid_q, araddr_q, rready, out_ready,
        output wready, rvalid, rdata, rresp, out_valid, out_key, out_din
    );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   push, din   : write request and data; ignored when the FIFO is full
//   pop, dout   : read request and head data; a pop is ignored when empty
//   full, empty : occupancy flags
//   level       : number of stored entries
// A simultaneous push and pop leaves level unchanged.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_s;
    logic             pop_s;

    assign full  = (level_r == LVL_FULL);
    assign empty = (level_r == {LW{1'b0}});
    assign level = level_r;
    assign dout  = mem_r[rd_ptr_r];

    // Gate requests so that overflow and underflow are no-ops.
    always_comb begin
        push_s = push & ~full;
        pop_s  = pop & ~empty;
    end

    // Payload storage; contents need no reset because level guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// -----------------------------------------------------------------------------
// aes_block_loader
// Assembles AES key/data blocks from 32-bit write beats. It buffers completed
// blocks in a FIFO and exposes byte count and status through a read channel.
// Ports:
//   clk_main_a0   : single clock
//   rst_main_sync : synchronous active-high reset
//   bus (slave)   : write beats, register reads and block output
//                   (see aes_block_loader_if)
// Write beat at LOAD_ADDR:
//   wdata[15:8] = key byte, wdata[7:0] = data byte (MSB first),
//   wdata[31:16] = LAST_MARKER on the final beat.
// Write beat at STATUS_ADDR:
//   wdata[1] clears err_short, wdata[2] clears err_missing.
// Optional feature macro: BLOCK_LOADER_MARKER_CHECK_EN.
//   Defined   : a block completes only when its final beat carries the marker;
//               an early marker sets err_short, and a missing marker sets
//               err_missing.
//   Undefined : a block completes on byte count alone, and both error bits
//               stay 0.
// -----------------------------------------------------------------------------
module aes_block_loader
    import aes_loader_pkg::*;
#(
    parameter int          BLOCK_BYTES = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] LOAD_ADDR   = DEF_LOAD_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_sync,
    aes_block_loader_if.slave bus
);
    localparam int BW    = BLOCK_BYTES * 8;
    localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             ready_en_r;
    logic [CNT_W-1:0] byte_cnt_r;
    logic [BW-1:0]    key_sr_r;
    logic [BW-1:0]    din_sr_r;
    logic [15:0]      blocks_done_r;
    logic             err_short_r;
    logic             err_missing_r;
    logic             rvalid_r;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;

    logic             beat_acc_s;
    logic             load_beat_s;
    logic             last_pos_s;
    logic [BW-1:0]    key_shift_s;
    logic [BW-1:0]    din_shift_s;
    logic [CNT_W-1:0] byte_cnt_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             set_short_s;
    logic             set_missing_s;
    logic             clr_short_s;
    logic             clr_missing_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic [2*BW-1:0]  fifo_dout_s;
    logic             out_valid_s;
    rd_sel_e          rd_sel_s;
    logic [31:0]      rd_data_s;
    logic [1:0]       rd_resp_s;

`ifdef BLOCK_LOADER_MARKER_CHECK_EN
    logic             marker_s;
    assign marker_s = (bus.wdata[31:16] == LAST_MARKER);
`else
    logic             unused_marker_s;
    assign unused_marker_s = ^bus.wdata[31:16];
`endif

    // ready_en_r holds wready low through reset and releases it one edge later.
    assign bus.wready  = ready_en_r & ~fifo_full_s;
    assign beat_acc_s  = bus.wvalid & bus.wready;
    assign last_pos_s  = (byte_cnt_r == LAST_CNT);
    assign key_shift_s = {key_sr_r[BW-9:0], bus.wdata[15:8]};
    assign din_shift_s = {din_sr_r[BW-9:0], bus.wdata[7:0]};
    assign out_valid_s = ~fifo_empty_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    assign bus.out_valid = out_valid_s;
    assign bus.out_key   = out_valid_s ? fifo_dout_s[2*BW-1:BW] : {BW{1'b0}};
    assign bus.out_din   = out_valid_s ? fifo_dout_s[BW-1:0]    : {BW{1'b0}};
    assign bus.rvalid    = rvalid_r;
    assign bus.rdata     = rdata_r;
    assign bus.rresp     = rresp_r;

    // Beat decode: byte count advance, block completion, error set/clear.
    always_comb begin
        load_beat_s    = 1'b0;
        push_s         = 1'b0;
        set_short_s    = 1'b0;
        set_missing_s  = 1'b0;
        clr_short_s    = 1'b0;
        clr_missing_s  = 1'b0;
        byte_cnt_nxt_s = byte_cnt_r;
        if (beat_acc_s && (bus.wr_addr == LOAD_ADDR)) begin
            load_beat_s = 1'b1;
`ifdef BLOCK_LOADER_MARKER_CHECK_EN
            if (marker_s && last_pos_s) begin
                push_s         = 1'b1;
                byte_cnt_nxt_s = {CNT_W{1'b0}};
            end else if (marker_s) begin
                set_short_s    = 1'b1;
                byte_cnt_nxt_s = {CNT_W{1'b0}};
            end else if (last_pos_s) begin
                set_missing_s  = 1'b1;
                byte_cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                byte_cnt_nxt_s = byte_cnt_r + CNT_ONE;
            end
`else
            if (last_pos_s) begin
                push_s         = 1'b1;
                byte_cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                byte_cnt_nxt_s = byte_cnt_r + CNT_ONE;
            end
`endif
        end else if (beat_acc_s && (bus.wr_addr == STATUS_ADDR)) begin
            clr_short_s   = bus.wdata[1];
            clr_missing_s = bus.wdata[2];
        end else begin
            load_beat_s = 1'b0;
        end
    end

    // Classify the read address.
    always_comb begin
        if (bus.araddr_q == LOAD_ADDR) begin
            rd_sel_s = RD_LOAD;
        end else if (bus.araddr_q == STATUS_ADDR) begin
            rd_sel_s = RD_STATUS;
        end else begin
            rd_sel_s = RD_OTHER;
        end
    end

    // Form the read response from the current state.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_OKAY;
        case (rd_sel_s)
            RD_LOAD:   rd_data_s = 32'(byte_cnt_r);
            RD_STATUS: rd_data_s = pack_status(blocks_done_r, 8'(fifo_level_s),
                                               err_missing_r, err_short_r, out_valid_s);
            default: begin
                rd_data_s = 32'h0000_0000;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // Write-side state: shift registers, byte count, block counter, sticky errors.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            ready_en_r    <= 1'b0;
            byte_cnt_r    <= {CNT_W{1'b0}};
            key_sr_r      <= {BW{1'b0}};
            din_sr_r      <= {BW{1'b0}};
            blocks_done_r <= 16'h0000;
            err_short_r   <= 1'b0;
            err_missing_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            byte_cnt_r <= byte_cnt_nxt_s;
            if (load_beat_s) begin
                key_sr_r <= key_shift_s;
                din_sr_r <= din_shift_s;
            end
            if (push_s) begin
                blocks_done_r <= blocks_done_r + 16'h0001;
            end
            err_short_r   <= (err_short_r & ~clr_short_s) | set_short_s;
            err_missing_r <= (err_missing_r & ~clr_missing_s) | set_missing_s;
        end
    end

    // Read channel: take a request only when idle, then hold until rready.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= RESP_OKAY;
        end else if (rvalid_r) begin
            if (bus.rready) begin
                rvalid_r <= 1'b0;
            end
        end else if (bus.arvalid_q) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end
    end

    sync_fifo #(
        .WIDTH (2 * BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_main_a0),
        .rst   (rst_main_sync),
        .push  (push_s),
        .din   ({key_shift_s, din_shift_s}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

endmodule
